iob_ext_mem_t2p_resp: RTL and testbench



---
 rtl/iob_ext_mem_t2p_resp_pkg.sv | 14 +
 rtl/iob_ext_mem_t2p_resp_pipe.sv | 49 ++++
 rtl/iob_ext_mem_t2p_resp.sv | 92 +++++++++
 tb/tb_iob_ext_mem_t2p_resp.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/iob_ext_mem_t2p_resp_pkg.sv
// Shared constants for the ext_mem true-two-port responder.
// Holds the FSM encoding, the read-latency ceiling and the depth helper.
package iob_ext_mem_t2p_resp_pkg;

    localparam logic CLEAR = 1'b0;
    localparam logic RUN   = 1'b1;

    localparam int MAX_READ_LAT = 4;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/iob_ext_mem_t2p_resp_pipe.sv
// Valid+data delay line carrying read results from the array to r_data_o.
// Latency: LAT registered stages, stage 1 loads on the accepting edge.
// Backpressure: none; cke_i low freezes every stage, including the output hold.
module iob_ext_mem_t2p_resp_pipe
    import iob_ext_mem_t2p_resp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int LAT    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_dat,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_dat
);

    localparam int LAT_C = (LAT > MAX_READ_LAT) ? MAX_READ_LAT : ((LAT < 1) ? 1 : LAT);

    logic [LAT_C-1:0]  stg_vld;
    logic [DATA_W-1:0] stg_dat [LAT_C];

    // Data regs only load behind a valid, so the last stage holds the
    // most recently returned value between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stg_vld <= '0;
            for (int k = 0; k < LAT_C; k++) begin
                stg_dat[k] <= '0;
            end
        end else if (cke_i) begin
            stg_vld[0] <= in_vld;
            if (in_vld) begin
                stg_dat[0] <= in_dat;
            end
            for (int k = 1; k < LAT_C; k++) begin
                stg_vld[k] <= stg_vld[k-1];
                if (stg_vld[k-1]) begin
                    stg_dat[k] <= stg_dat[k-1];
                end
            end
        end
    end

    assign out_vld = stg_vld[LAT_C-1];
    assign out_dat = stg_dat[LAT_C-1];

endmodule

// File: rtl/iob_ext_mem_t2p_resp.sv
// ext_mem t2p responder: register array, post-reset scrub, one write + one read per cycle.
// Latency: read data READ_LAT cycles after request; IOB_EXT_MEM_T2P_RESP_BYPASS_EN selects write-first.
// Backpressure: ready_o low during scrub; requests then are dropped and flag sticky err_o.
module iob_ext_mem_t2p_resp
    import iob_ext_mem_t2p_resp_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int READ_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              w_en_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic              r_en_i,
    input  logic [ADDR_W-1:0] r_addr_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic              r_valid_o,
    output logic              ready_o,
    output logic              err_o
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic              state;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              err_q;
    logic              rd_vld;
    logic              wr_vld;
    logic [DATA_W-1:0] rd_dat;

    assign rd_vld = cke_i & (state == RUN) & r_en_i;
    assign wr_vld = cke_i & (state == RUN) & w_en_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= CLEAR;
            clr_addr <= '0;
            err_q    <= 1'b0;
        end else if (cke_i) begin
            if (state == CLEAR) begin
                clr_addr <= clr_addr + ADDR_W'(1);
                if (clr_addr == {ADDR_W{1'b1}}) begin
                    state <= RUN;
                end
            end
            if ((state != RUN) && (w_en_i || r_en_i)) begin
                err_q <= 1'b1;
            end
        end
    end

    // The array itself is never reset; the scrub pass provides known contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i && cke_i) begin
            if (state == CLEAR) begin
                mem[clr_addr] <= '0;
            end else if (wr_vld) begin
                mem[w_addr_i] <= w_data_i;
            end
        end
    end

    always_comb begin
        rd_dat = mem[r_addr_i];
`ifdef IOB_EXT_MEM_T2P_RESP_BYPASS_EN
        if (wr_vld && (w_addr_i == r_addr_i)) begin
            rd_dat = w_data_i;
        end
`endif
    end

    iob_ext_mem_t2p_resp_pipe #(
        .DATA_W (DATA_W),
        .LAT    (READ_LAT)
    ) u_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cke_i   (cke_i),
        .in_vld  (rd_vld),
        .in_dat  (rd_dat),
        .out_vld (r_valid_o),
        .out_dat (r_data_o)
    );

    assign ready_o = state;
    assign err_o   = err_q;

endmodule

// File: tb/tb_iob_ext_mem_t2p_resp.sv
// Scoreboard bench: a READ_LAT=2 and a READ_LAT=1 responder share one stimulus stream.
module tb_iob_ext_mem_t2p_resp;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       cke_i = 1'b1;
    logic       w_en_i = 1'b0;
    logic [3:0] w_addr_i = '0;
    logic [7:0] w_data_i = '0;
    logic       r_en_i = 1'b0;
    logic [3:0] r_addr_i = '0;
    logic [7:0] r_data_o, r_data1;
    logic       r_valid_o, r_valid1;
    logic       ready_o, ready1;
    logic       err_o, err1;

    always #5 clk = ~clk;

    iob_ext_mem_t2p_resp #(.DATA_W(8), .ADDR_W(4), .READ_LAT(2)) dut (
        .clk_i(clk), .rst_i(rst_i), .cke_i(cke_i),
        .w_en_i(w_en_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .r_en_i(r_en_i), .r_addr_i(r_addr_i),
        .r_data_o(r_data_o), .r_valid_o(r_valid_o), .ready_o(ready_o), .err_o(err_o)
    );

    iob_ext_mem_t2p_resp #(.DATA_W(8), .ADDR_W(4), .READ_LAT(1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .cke_i(cke_i),
        .w_en_i(w_en_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i),
        .r_en_i(r_en_i), .r_addr_i(r_addr_i),
        .r_data_o(r_data1), .r_valid_o(r_valid1), .ready_o(ready1), .err_o(err1)
    );

    typedef struct {
        int         due;
        logic [7:0] dat;
    } exp_t;

    exp_t       q2[$];
    exp_t       q1[$];
    logic [7:0] mem_m [16];
    bit         ready_m = 1'b0;
    bit         err_m = 1'b0;
    int         clr_m = 0;
    int         en_cyc = 0;
    bit         expv2 = 1'b0;
    bit         expv1 = 1'b0;
    logic [7:0] last2 = '0;
    logic [7:0] last1 = '0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] collide_exp;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive, advance the reference model across the edge, compare.
    task automatic step(input bit rst, input bit cke, input bit we, input logic [3:0] wa,
                        input logic [7:0] wd, input bit re, input logic [3:0] ra);
        exp_t e;
        rst_i = rst; cke_i = cke;
        w_en_i = we; w_addr_i = wa; w_data_i = wd;
        r_en_i = re; r_addr_i = ra;
        @(posedge clk);
        #1;
        if (rst) begin
            q2.delete(); q1.delete();
            ready_m = 1'b0; err_m = 1'b0; clr_m = 0;
            expv2 = 1'b0; expv1 = 1'b0; last2 = '0; last1 = '0;
        end else if (cke) begin
            en_cyc++;
            if (ready_m) begin
                if (re) begin
                    e.dat = mem_m[ra];
`ifdef IOB_EXT_MEM_T2P_RESP_BYPASS_EN
                    if (we && wa == ra) e.dat = wd;
`endif
                    e.due = en_cyc + 1; q2.push_back(e);
                    e.due = en_cyc;     q1.push_back(e);
                end
                if (we) mem_m[wa] = wd;
            end else begin
                if (we || re) err_m = 1'b1;
                mem_m[clr_m] = '0;
                clr_m++;
                if (clr_m == 16) ready_m = 1'b1;
            end
            expv2 = (q2.size() > 0) && (q2[0].due == en_cyc);
            if (expv2) begin last2 = q2[0].dat; void'(q2.pop_front()); end
            expv1 = (q1.size() > 0) && (q1[0].due == en_cyc);
            if (expv1) begin last1 = q1[0].dat; void'(q1.pop_front()); end
        end
        chk("ready", ready_o, ready_m);
        chk("err", err_o, err_m);
        chk("rvalid_lat2", r_valid_o, expv2);
        chk("rdata_lat2", r_data_o, last2);
        chk("rvalid_lat1", r_valid1, expv1);
        chk("rdata_lat1", r_data1, last1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 4'h0, 8'h00, 0, 4'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        step(0, 1, 1, a, d, 0, 4'h0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(0, 1, 0, 4'h0, 8'h00, 1, a);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
`ifdef IOB_EXT_MEM_T2P_RESP_BYPASS_EN
        collide_exp = 8'h3C;
`else
        collide_exp = 8'h11;
`endif
        // Reset and scrub, then read the whole cleared array back-to-back.
        step(1, 1, 0, 4'h0, 8'h00, 0, 4'h0);
        step(1, 0, 0, 4'h0, 8'h00, 0, 4'h0);
        chk("reset_ready", ready_o, 0);
        chk("reset_rdata", r_data_o, 0);
        idle(15);
        chk("scrub_ready_low", ready_o, 0);
        idle(1);
        chk("scrub_ready_high", ready_o, 1);
        for (int i = 0; i < 16; i++) rd(4'(i));
        idle(3);

        // Write then read, both latencies.
        wr(4'h3, 8'hA5);
        rd(4'h3);
        idle(3);
        chk("wr_rd_lat2", r_data_o, 8'hA5);
        chk("wr_rd_lat1", r_data1, 8'hA5);

        // Same-cycle collision.
        wr(4'h5, 8'h11);
        idle(1);
        step(0, 1, 1, 4'h5, 8'h3C, 1, 4'h5);
        idle(3);
        chk("collide", r_data_o, collide_exp);
        rd(4'h5);
        idle(3);
        chk("collide_after", r_data_o, 8'h3C);

        // Requests during scrub are ignored and make err_o sticky.
        step(1, 1, 0, 4'h0, 8'h00, 0, 4'h0);
        step(0, 1, 1, 4'h2, 8'hFF, 1, 4'h2);
        chk("err_set", err_o, 1);
        idle(15);
        chk("err_sticky_run", err_o, 1);
        rd(4'h2);
        idle(3);
        chk("scrub_req_dropped", r_data_o, 8'h00);
        chk("err_still_set", err_o, 1);

        // Stream 16 reads with a 3-cycle clock-enable gap in the middle.
        for (int i = 0; i < 16; i++) wr(4'(i), 8'(8'h10 + i));
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                for (int j = 0; j < 3; j++) step(0, 0, 0, 4'h0, 8'h00, 1, 4'(i));
            end
            rd(4'(i));
        end
        idle(3);
        chk("stream_last", r_data_o, 8'h1F);

        // Reset with reads in flight: nothing returns, scrub restarts.
        rd(4'h7);
        rd(4'h8);
        step(1, 1, 0, 4'h0, 8'h00, 0, 4'h0);
        chk("rst_flight_rdata", r_data_o, 0);
        chk("rst_flight_ready", ready_o, 0);
        chk("rst_clears_err", err_o, 0);
        idle(16);
        chk("rescrub_ready", ready_o, 1);
        rd(4'h7);
        idle(3);
        chk("rescrub_rd7", r_data_o, 8'h00);
        chk("rescrub_rd7_lat1", r_data1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=%0d exp=0", checks);
        $fatal(1, "timeout");
    end

endmodule
